// File: rtl/ex_branch_stage.sv
// Execute-stage branch resolver: registers the ALU result, decides branch/jump taken,
// emits a one-cycle fetch redirect and squashes the wrong-path beats that follow it.
module ex_branch_stage #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] result_i,
    input  logic            zero_i,
    input  logic            negative_i,
    input  logic            overflow_i,
    input  logic            carry_i,
    input  logic            branch_i,
    input  logic            jump_i,
    input  logic            jalr_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            taken_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            illegal_o
);

    typedef enum logic {RUN, SQUASH} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            taken_q, taken_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            illegal_q, illegal_d;

    logic            accept;
    logic            cond_ok;
    logic            is_illegal;
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] beat_result;

    // carry_i is a borrow flag: set when rs1 <u rs2.
    function automatic logic cond_true(input logic [2:0] f3, input logic z, input logic n,
                                       input logic v, input logic c);
        case (f3)
            3'b000:  cond_true = z;
            3'b001:  cond_true = ~z;
            3'b100:  cond_true = n ^ v;
            3'b101:  cond_true = ~(n ^ v);
            3'b110:  cond_true = c;
            3'b111:  cond_true = ~c;
            default: cond_true = 1'b0;
        endcase
    endfunction

    assign cond_ok     = cond_true(funct3_i, zero_i, negative_i, overflow_i, carry_i);
    assign is_illegal  = branch_i & (funct3_i[2:1] == 2'b01);
    assign taken       = jump_i | (branch_i & cond_ok);
    assign target      = (jump_i & jalr_i) ? {result_i[XLEN-1:1], 1'b0} : pc_i + imm_i;
    assign beat_result = jump_i ? pc_i + XLEN'(4) : result_i;

    assign ready_o = (state_q == SQUASH) | ~valid_q | ready_i;
    assign accept  = valid_i & ready_o & (state_q == RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (accept && taken) begin
                    state_d = SQUASH;
                    cnt_d   = 4'(FLUSH_CYCLES);
                end
            end
            SQUASH: begin
                if (valid_i) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        valid_d       = valid_q;
        result_d      = result_q;
        taken_d       = taken_q;
        redirect_pc_d = redirect_pc_q;
        illegal_d     = illegal_q;
        redirect_d    = 1'b0;
        if (accept) begin
            valid_d       = 1'b1;
            result_d      = beat_result;
            taken_d       = taken;
            redirect_pc_d = target;
            illegal_d     = is_illegal;
            redirect_d    = taken;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            valid_q       <= 1'b0;
            result_q      <= '0;
            taken_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            valid_q       <= valid_d;
            result_q      <= result_d;
            taken_q       <= taken_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            illegal_q     <= illegal_d;
        end
    end

    assign valid_o       = valid_q;
    assign result_o      = result_q;
    assign taken_o       = taken_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_ex_branch_stage.sv
// Scoreboard bench for ex_branch_stage: directed beats push expected outputs,
// a negedge monitor pops and compares every beat consumed downstream.
module tb_ex_branch_stage;

    logic        clk, rst_n;
    logic        valid_i, ready_o, ready_i, valid_o;
    logic [31:0] result_i, pc_i, imm_i, result_o, redirect_pc_o;
    logic        zero_i, negative_i, overflow_i, carry_i;
    logic        branch_i, jump_i, jalr_i;
    logic [2:0]  funct3_i;
    logic        taken_o, redirect_o, illegal_o;

    typedef struct {
        logic [31:0] res;
        logic        taken;
        logic [31:0] rpc;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   ntests = 0;
    int   nfail  = 0;

    ex_branch_stage #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .result_i(result_i), .zero_i(zero_i), .negative_i(negative_i),
        .overflow_i(overflow_i), .carry_i(carry_i), .branch_i(branch_i),
        .jump_i(jump_i), .jalr_i(jalr_i), .funct3_i(funct3_i), .pc_i(pc_i),
        .imm_i(imm_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
        .taken_o(taken_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .illegal_o(illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents one beat, holds it until the handshake completes, returns 1 ns after that edge.
    task automatic send(input logic br, input logic jp, input logic jr, input logic [2:0] f3,
                        input logic z, input logic n, input logic v, input logic c,
                        input logic [31:0] res, input logic [31:0] pc, input logic [31:0] imm,
                        input bit emit, input logic [31:0] e_res, input logic e_tk,
                        input logic [31:0] e_rpc, input logic e_ill);
        bit   acc;
        exp_t e;
        branch_i = br; jump_i = jp; jalr_i = jr; funct3_i = f3;
        zero_i = z; negative_i = n; overflow_i = v; carry_i = c;
        result_i = res; pc_i = pc; imm_i = imm;
        valid_i = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        if (!acc) begin
            ntests++;
            nfail++;
            $display("FAIL accept_timeout: got ready_o=0, expected handshake within 20 cycles");
        end else if (emit) begin
            e.res = e_res; e.taken = e_tk; e.rpc = e_rpc; e.ill = e_ill;
            sb.push_back(e);
        end
    endtask

    task automatic drop_beat();
        send(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0,
             32'hDEAD, 32'h500, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("squash_no_valid", {31'b0, valid_o}, 32'd0);
    endtask

    // Monitor: redirect must appear only on the first cycle a beat is presented.
    logic        held = 1'b0;
    logic        first_red;
    logic [31:0] first_rpc;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (valid_o) begin
                if (!held) begin
                    first_red = redirect_o;
                    first_rpc = redirect_pc_o;
                end else if (redirect_o) begin
                    ntests++;
                    nfail++;
                    $display("FAIL redirect_extra: got redirect_o=1, expected 0 on held beat");
                end
                if (ready_i) begin
                    if (sb.size() == 0) begin
                        ntests++;
                        nfail++;
                        $display("FAIL unexpected_beat: got result_o=0x%0h, expected no beat", result_o);
                    end else begin
                        e = sb.pop_front();
                        chk("mon_result", result_o, e.res);
                        chk("mon_taken", {31'b0, taken_o}, {31'b0, e.taken});
                        chk("mon_illegal", {31'b0, illegal_o}, {31'b0, e.ill});
                        chk("mon_redirect", {31'b0, first_red}, {31'b0, e.taken});
                        if (e.taken) chk("mon_redirect_pc", first_rpc, e.rpc);
                    end
                end
            end else if (redirect_o) begin
                ntests++;
                nfail++;
                $display("FAIL redirect_idle: got redirect_o=1, expected 0 with valid_o=0");
            end
            held = valid_o & ~ready_i;
        end
    end

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        branch_i = 1'b0; jump_i = 1'b0; jalr_i = 1'b0; funct3_i = 3'b000;
        zero_i = 1'b0; negative_i = 1'b0; overflow_i = 1'b0; carry_i = 1'b0;
        result_i = '0; pc_i = '0; imm_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_taken", {31'b0, taken_o}, 32'd0);
        chk("rst_redirect", {31'b0, redirect_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_rpc", redirect_pc_o, 32'd0);
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // BEQ taken, then squash window of two beats, third beat emitted
        send(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0,
             32'h55, 32'h100, 32'h20, 1'b1, 32'h55, 1'b1, 32'h120, 1'b0);
        chk("beq_valid", {31'b0, valid_o}, 32'd1);
        chk("beq_redirect", {31'b0, redirect_o}, 32'd1);
        chk("beq_rpc", redirect_pc_o, 32'h120);
        drop_beat();
        chk("redirect_one_cycle", {31'b0, redirect_o}, 32'd0);
        drop_beat();
        send(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h1234, 32'h600, 32'h0, 1'b1, 32'h1234, 1'b0, 32'h0, 1'b0);
        chk("post_squash_latency", {31'b0, valid_o}, 32'd1);

        // BLTU with borrow, BGE with N=V, BNE with zero set (not taken)
        send(1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1,
             32'hFFFF_FFF0, 32'h200, 32'hFFFF_FFF0, 1'b1, 32'hFFFF_FFF0, 1'b1, 32'h1F0, 1'b0);
        drop_beat(); drop_beat();
        send(1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 1'b1, 1'b1, 1'b0,
             32'h7, 32'h300, 32'h8, 1'b1, 32'h7, 1'b1, 32'h308, 1'b0);
        drop_beat(); drop_beat();
        send(1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0,
             32'h0, 32'h340, 32'h40, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);

        // JALR clears bit 0; JAL with branch also set wraps past 2^32
        send(1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h2005, 32'h40, 32'h0, 1'b1, 32'h44, 1'b1, 32'h2004, 1'b0);
        drop_beat(); drop_beat();
        send(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h9, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'hFFFF_FFF4, 1'b1, 32'h10, 1'b0);
        drop_beat(); drop_beat();

        // Backpressure: output held 4 cycles, then drain and accept together
        ready_i = 1'b0;
        send(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0,
             32'hAAAA, 32'h700, 32'h0, 1'b1, 32'hAAAA, 1'b0, 32'h0, 1'b0);
        branch_i = 1'b0; jump_i = 1'b0; result_i = 32'hBBBB; pc_i = 32'h704;
        valid_i = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("bp_ready_low", {31'b0, ready_o}, 32'd0);
            chk("bp_result_stable", result_o, 32'hAAAA);
            chk("bp_valid_held", {31'b0, valid_o}, 32'd1);
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'b0, ready_o}, 32'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        sb.push_back('{res: 32'hBBBB, taken: 1'b0, rpc: 32'h0, ill: 1'b0});
        chk("bp_accept_valid", {31'b0, valid_o}, 32'd1);
        chk("bp_accept_result", result_o, 32'hBBBB);

        // Reserved funct3 flags illegal and is never taken
        send(1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0,
             32'h77, 32'h800, 32'h10, 1'b1, 32'h77, 1'b0, 32'h0, 1'b1);
        chk("illegal_flag", {31'b0, illegal_o}, 32'd1);
        chk("illegal_no_redirect", {31'b0, redirect_o}, 32'd0);

        // Reset during SQUASH clears everything; the next beat is processed normally
        send(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0,
             32'h11, 32'h80, 32'h10, 1'b1, 32'h11, 1'b1, 32'h90, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_valid", {31'b0, valid_o}, 32'd0);
        chk("mid_rst_redirect", {31'b0, redirect_o}, 32'd0);
        chk("mid_rst_taken", {31'b0, taken_o}, 32'd0);
        chk("mid_rst_result", result_o, 32'd0);
        chk("mid_rst_rpc", redirect_pc_o, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0,
             32'hCAFE, 32'h900, 32'h0, 1'b1, 32'hCAFE, 1'b0, 32'h0, 1'b0);
        chk("post_rst_beat", {31'b0, valid_o}, 32'd1);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
